// File: rtl/pwm_capture.sv
// pwm_capture: receive side of the fan PWM path.
//
// Measures an asynchronous PWM input and reports the period and high time
// in clk cycles, together with the duty cycle scaled to the N-bit range
// used by the fan PWM generator (0 .. 2^N-1). A timeout flags an input
// that is stuck high or stuck low.
//
// Ports:
//   clk        in   system clock
//   reset_p    in   asynchronous, active-high reset
//   pwm_in     in   asynchronous PWM input
//   period     out  [CNT_W] last measured period in clk cycles, 0 after timeout
//   high_time  out  [CNT_W] last measured high time in clk cycles, 0 after timeout
//   duty       out  [N]     floor(high_time*2^N/period), saturated to 2^N-1
//   valid      out          one-cycle strobe, outputs update in the same cycle
//   stuck      out          timeout without rising edge; duty shows stuck level
//   busy       out          divider running
module pwm_capture #(
    parameter int SYS_FREQ = 125,    // clk frequency in MHz
    parameter int N        = 12,     // duty width
    parameter int MIN_FREQ = 50,     // lowest valid PWM frequency in Hz
    parameter int CNT_W    = 24      // period / high-time counter width
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [N-1:0]     duty,
    output logic             valid,
    output logic             stuck,
    output logic             busy
);

    localparam longint TIMEOUT_L =
        longint'(SYS_FREQ) * longint'(1000000) / longint'(MIN_FREQ);
    localparam logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(TIMEOUT_L);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [N-1:0]     DUTY_FULL   = '1;
    localparam int               BIT_W       = $clog2(N);

    // Refuse to build a block whose timeout cannot be represented.
    if (TIMEOUT_L >= (longint'(1) << CNT_W)) begin : g_timeout_check
        $error("pwm_capture: TIMEOUT_CYC does not fit in CNT_W bits");
    end

    typedef enum logic [1:0] {
        S_ARM = 2'd0,
        S_RUN = 2'd1,
        S_DIV = 2'd2
    } state_t;

    // Counter increment saturating at the timeout value.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic             inc);
        if (a >= TIMEOUT_CYC) return TIMEOUT_CYC;
        return a + {{(CNT_W-1){1'b0}}, inc};
    endfunction

    // Duty result: clamp to full scale when high time is not below period.
    function automatic logic [N-1:0] sat_duty(input logic         sat,
                                              input logic [N-1:0] q);
        return sat ? DUTY_FULL : q;
    endfunction

    state_t           state_q;

    logic             sync1_q, sync2_q, prev_q;
    logic             rise;

    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q,  hi_cnt_d;
    logic             to_done_q, to_done_d;
    logic             timeout;

    logic [CNT_W-1:0] p_q, h_q, rem_q, rem_nx;
    logic [CNT_W-1:0] rem_sh;
    logic             rem_carry, ge;
    logic [N-1:0]     quo_q, quo_nx;
    logic [BIT_W-1:0] bit_q;
    logic             sat_q;
    logic             last_step;

    logic [CNT_W-1:0] period_q, high_q;
    logic [N-1:0]     duty_q;
    logic             valid_q, stuck_q, busy_q;

    // s_in is sync2_q; prev_q is the edge-detect register.
    assign rise = sync2_q & ~prev_q;

    always_comb begin
        run_cnt_d = rise ? CNT_ONE : sat_add(run_cnt_q, 1'b1);
        hi_cnt_d  = rise ? CNT_ONE : sat_add(hi_cnt_q, sync2_q);

        // to_done_q remembers that this saturation already produced its
        // strobe, so a counter parked at the limit does not fire again.
        // A rise in the same cycle takes priority over the timeout.
        timeout   = (run_cnt_q == TIMEOUT_CYC) && !to_done_q && !rise;
        to_done_d = !rise && (to_done_q || timeout);

        // One restoring-division step. The dividend is H followed by N zero
        // bits, so each step only shifts a zero into the partial remainder.
        // The bit shifted out of the top counts as an implicit carry; the
        // true difference is always below P, so modulo arithmetic is exact.
        rem_carry = rem_q[CNT_W-1];
        rem_sh    = {rem_q[CNT_W-2:0], 1'b0};
        ge        = rem_carry || (rem_sh >= p_q);
        rem_nx    = ge ? (rem_sh - p_q) : rem_sh;
        quo_nx    = {quo_q[N-2:0], ge};
        last_step = (bit_q == BIT_W'(N-1));
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q   <= S_ARM;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            run_cnt_q <= '0;
            hi_cnt_q  <= '0;
            to_done_q <= 1'b0;
            p_q       <= '0;
            h_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            bit_q     <= '0;
            sat_q     <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync1_q   <= pwm_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            run_cnt_q <= run_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            to_done_q <= to_done_d;
            valid_q   <= 1'b0;

            if (timeout) begin
                // Timeout overrides whatever the FSM was doing.
                period_q <= '0;
                high_q   <= '0;
                duty_q   <= sync2_q ? DUTY_FULL : '0;
                stuck_q  <= 1'b1;
                valid_q  <= 1'b1;
                busy_q   <= 1'b0;
                state_q  <= S_ARM;
            end else begin
                unique case (state_q)
                    S_ARM: begin
                        // First rise only establishes a period start.
                        if (rise) state_q <= S_RUN;
                    end
                    S_RUN: begin
                        if (rise) begin
                            p_q     <= run_cnt_q;
                            h_q     <= hi_cnt_q;
                            rem_q   <= hi_cnt_q;
                            quo_q   <= '0;
                            bit_q   <= '0;
                            sat_q   <= (hi_cnt_q >= run_cnt_q);
                            busy_q  <= 1'b1;
                            state_q <= S_DIV;
                        end
                    end
                    S_DIV: begin
                        if (rise) begin
                            // Period shorter than the division: drop it.
                            busy_q  <= 1'b0;
                            state_q <= S_RUN;
                        end else begin
                            rem_q <= rem_nx;
                            quo_q <= quo_nx;
                            bit_q <= bit_q + BIT_W'(1);
                            if (last_step) begin
                                period_q <= p_q;
                                high_q   <= h_q;
                                duty_q   <= sat_duty(sat_q, quo_nx);
                                stuck_q  <= 1'b0;
                                valid_q  <= 1'b1;
                                busy_q   <= 1'b0;
                                state_q  <= S_RUN;
                            end
                        end
                    end
                    default: state_q <= S_ARM;
                endcase
            end
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign duty      = duty_q;
    assign valid     = valid_q;
    assign stuck     = stuck_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture.
// Runs with a 1 MHz / 500 Hz parameter set so the timeout is 2000 cycles.
`timescale 1ns/1ps

module tb_pwm_capture;
  localparam int N     = 12;
  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             reset_p;
  logic             pwm_in;
  logic [CNT_W-1:0] period, high_time;
  logic [N-1:0]     duty;
  logic             valid, stuck, busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0, vcnt = 0, brise = 0, bstart = 0, lat = 0;
  logic [CNT_W-1:0] lp = '0, lh = '0;
  logic [N-1:0]     ld = '0;
  logic             ls = 1'b0;
  logic             busy_d = 1'b0;
  int               v0, b0;
  logic             got;

  pwm_capture #(
    .SYS_FREQ(1), .N(N), .MIN_FREQ(500), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_p(reset_p), .pwm_in(pwm_in),
    .period(period), .high_time(high_time), .duty(duty),
    .valid(valid), .stuck(stuck), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe and the busy-to-valid distance.
  always @(negedge clk) begin
    if (busy && !busy_d) begin
      bstart = cyc;
      brise++;
    end
    busy_d = busy;
    if (valid) begin
      vcnt++;
      lp  = period;
      lh  = high_time;
      ld  = duty;
      ls  = stuck;
      lat = cyc - bstart;
    end
  end

  task automatic chk(input string tag, input logic ok,
                     input longint obs, input longint exp);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pwm(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      pwm_in = 1'b1;
      repeat (hi) @(negedge clk);
      pwm_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_p = 1'b1;
    pwm_in  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", period === 0, period, 0);
    chk("rst_high", high_time === 0, high_time, 0);
    chk("rst_duty", duty === 0, duty, 0);
    chk("rst_valid", valid === 1'b0, valid, 0);
    chk("rst_stuck", stuck === 1'b0, stuck, 0);
    chk("rst_busy", busy === 1'b0, busy, 0);
    reset_p = 1'b0;
    @(negedge clk);

    // 50 % duty, 1000-cycle period
    pwm(500, 500, 1);
    chk("arm_no_valid", vcnt == 0, vcnt, 0);
    pwm(500, 500, 3);
    chk("p50_count", vcnt == 3, vcnt, 3);
    chk("p50_period", lp === 1000, lp, 1000);
    chk("p50_high", lh === 500, lh, 500);
    chk("p50_duty", ld === 2048, ld, 2048);
    chk("p50_stuck", ls === 1'b0, ls, 0);
    chk("p50_latency", lat == N, lat, N);

    // 25 % duty
    pwm(250, 750, 3);
    chk("p25_count", vcnt == 6, vcnt, 6);
    chk("p25_period", lp === 1000, lp, 1000);
    chk("p25_high", lh === 250, lh, 250);
    chk("p25_duty", ld === 1024, ld, 1024);

    // 999/1000 duty
    pwm(999, 1, 2);
    chk("p999_count", vcnt == 8, vcnt, 8);
    chk("p999_high", lh === 999, lh, 999);
    chk("p999_duty", ld === 4091, ld, 4091);
    chk("p999_latency", lat == N, lat, N);

    // stuck high
    pwm(500, 500, 2);
    v0 = vcnt;
    pwm_in = 1'b1;
    repeat (2100) @(negedge clk);
    chk("sh_count", vcnt == v0 + 2, vcnt, v0 + 2);
    chk("sh_stuck", ls === 1'b1, ls, 1);
    chk("sh_duty", ld === 4095, ld, 4095);
    chk("sh_period", lp === 0, lp, 0);
    chk("sh_high", lh === 0, lh, 0);
    repeat (2500) @(negedge clk);
    chk("sh_no_repeat", vcnt == v0 + 2, vcnt, v0 + 2);

    // resume: no edge, then arming period, then measurements
    v0 = vcnt;
    pwm(500, 500, 2);
    chk("resume_arm_count", vcnt == v0, vcnt, v0);
    chk("resume_arm_stuck", ls === 1'b1, ls, 1);
    pwm(500, 500, 2);
    chk("resume_count", vcnt == v0 + 2, vcnt, v0 + 2);
    chk("resume_stuck", ls === 1'b0, ls, 0);
    chk("resume_duty", ld === 2048, ld, 2048);

    // stuck low
    v0 = vcnt;
    repeat (2100) @(negedge clk);
    chk("sl_count", vcnt == v0 + 1, vcnt, v0 + 1);
    chk("sl_duty", ld === 0, ld, 0);
    chk("sl_stuck", ls === 1'b1, ls, 1);
    chk("sl_period", lp === 0, lp, 0);

    // period shorter than the divider
    pwm(500, 500, 3);
    chk("pre_short_duty", ld === 2048, ld, 2048);
    v0 = vcnt;
    b0 = brise;
    pwm(5, 5, 30);
    chk("short_no_valid", vcnt == v0, vcnt, v0);
    chk("short_period_hold", lp === 1000, lp, 1000);
    chk("short_high_hold", lh === 500, lh, 500);
    chk("short_duty_hold", ld === 2048, ld, 2048);
    chk("short_busy_toggles", (brise - b0) >= 10, brise - b0, 10);

    // reset while busy
    pwm(500, 500, 2);
    pwm_in = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin
        got = 1'b1;
        break;
      end
    end
    chk("busy_seen", got === 1'b1, got, 1);
    #1 reset_p = 1'b1;
    #1;
    chk("mid_rst_period", period === 0, period, 0);
    chk("mid_rst_high", high_time === 0, high_time, 0);
    chk("mid_rst_duty", duty === 0, duty, 0);
    chk("mid_rst_valid", valid === 1'b0, valid, 0);
    chk("mid_rst_stuck", stuck === 1'b0, stuck, 0);
    chk("mid_rst_busy", busy === 1'b0, busy, 0);
    @(negedge clk);
    reset_p = 1'b0;
    v0 = vcnt;
    repeat (500) @(negedge clk);
    pwm_in = 1'b0;
    repeat (500) @(negedge clk);
    chk("post_rst_arm", vcnt == v0, vcnt, v0);
    pwm(500, 500, 1);
    chk("post_rst_count", vcnt == v0 + 1, vcnt, v0 + 1);
    chk("post_rst_period", lp === 1000, lp, 1000);
    chk("post_rst_high", lh === 500, lh, 500);

    // edges off the clock grid
    v0 = vcnt;
    @(negedge clk);
    #3;
    for (int k = 0; k < 4; k++) begin
      pwm_in = 1'b1;
      #2996.6;
      pwm_in = 1'b0;
      #7003.4;
    end
    chk("async_count", vcnt == v0 + 4, vcnt, v0 + 4);
    chk("async_period", (lp >= 999) && (lp <= 1001), lp, 1000);
    chk("async_high", (lh >= 299) && (lh <= 301), lh, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
